// File: rtl/display_pkg.sv
// display_pkg -- shared types and constants for the multiplexed display scanner.
//   phase_t   : slot phase, BLANK (guard, everything off) or DRIVE.
//   SEG_BLANK : all segments dark (outputs are active-low).
//   DIG_ON/DIG_OFF, SEG_ON/SEG_OFF : active-low polarity of digit and segment lines.
package display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic DIG_ON  = 1'b0;
    localparam logic DIG_OFF = 1'b1;
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;

endpackage

// File: rtl/SevenSeg_Decoder.sv
// SevenSeg_Decoder -- hex nibble to active-low seven-segment pattern.
//   nibble : input  [3:0] hex value 0..F
//   seg_n  : output [6:0] segments g..a (bit 0 = a), 0 = lit
module SevenSeg_Decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        case (nibble)
            4'h0:    seg_n = 7'h40;
            4'h1:    seg_n = 7'h79;
            4'h2:    seg_n = 7'h24;
            4'h3:    seg_n = 7'h30;
            4'h4:    seg_n = 7'h19;
            4'h5:    seg_n = 7'h12;
            4'h6:    seg_n = 7'h02;
            4'h7:    seg_n = 7'h78;
            4'h8:    seg_n = 7'h00;
            4'h9:    seg_n = 7'h10;
            4'hA:    seg_n = 7'h08;
            4'hB:    seg_n = 7'h03;
            4'hC:    seg_n = 7'h46;
            4'hD:    seg_n = 7'h21;
            4'hE:    seg_n = 7'h06;
            default: seg_n = 7'h0E;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// display_scanner -- time-multiplexed seven-segment display driver.
//   clk, rst   : clock (rising edge) and synchronous active-high reset
//   digits_in  : one hex nibble per digit, digit 0 in bits 3:0
//   dp_in      : decimal point per digit, 1 = lit
//   update     : one-cycle request; data is captured at the next frame boundary
//   lz_en      : leading-zero suppression enable
//   brightness : PWM duty, 0 = dark
//   dig_sel    : active-low digit enables (at most one low)
//   seg_out    : active-low segments, bit 7 = dp
//   frame_done : one-cycle pulse when the digit index wraps to 0
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BRIGHT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    update,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [7:0]              seg_out,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_CYCLES);
    // A single digit still needs a 1-bit index register; it simply stays 0.
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending;

    logic                    slot_end, last_dig, frame_wrap;
    phase_t                  phase;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   sup;
    logic                    zrun;
    logic                    digit_on;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic [7:0]              seg_d;

    assign slot_end   = (scan_cnt == CNT_W'(SCAN_CYCLES - 1));
    assign last_dig   = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = slot_end && last_dig;
    assign phase      = (scan_cnt < CNT_W'(BLANK_CYCLES)) ? BLANK : DRIVE;

    // Slot counter, digit index and free-running PWM counter
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (slot_end) begin
                scan_cnt <= '0;
                idx      <= last_dig ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Shadow capture: requests are merged into one pending flag and only
    // take effect at the frame boundary, so a frame never shows mixed data.
    // A request on the boundary cycle itself is honoured immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else if (frame_wrap) begin
            if (pending || update) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
            end
            pending <= 1'b0;
        end else if (update) begin
            pending <= 1'b1;
        end
    end

    // Leading-zero run from the top digit down: sup[k] means digits
    // k..NUM_DIGITS-1 are all zero with no dp. Digit 0 is never suppressed.
    always_comb begin
        sup  = '0;
        zrun = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zrun   = zrun && (shadow_dig[4*k +: 4] == 4'h0) && !shadow_dp[k];
            sup[k] = zrun;
        end
    end

    // Current-digit mux
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib = shadow_dig[4*k +: 4];
                cur_dp  = shadow_dp[k];
            end
        end
    end

    SevenSeg_Decoder u_dec (
        .nibble (cur_nib),
        .seg_n  (dec_seg)
    );

    assign digit_on = (phase == DRIVE) && (brightness > pwm_cnt) && !(lz_en && sup[idx]);

    always_comb begin
        sel_d = {NUM_DIGITS{DIG_OFF}};
        seg_d = SEG_BLANK;
        if (digit_on) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx == IDX_W'(k))
                    sel_d[k] = DIG_ON;
            end
            seg_d = {cur_dp ? SEG_ON : SEG_OFF, dec_seg};
        end
    end

    // Registered outputs, one clock behind the counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_sel    <= {NUM_DIGITS{DIG_OFF}};
            seg_out    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            dig_sel    <= sel_d;
            seg_out    <= seg_d;
            frame_done <= frame_wrap;
        end
    end

endmodule
